// File: rtl/ir_nec_frontend.sv
// NEC IR pulse-width decoder that replays each frame as a start-marked bitstream.
// Optional build macro IR_REPEAT_EN: replay the last frame on a repeat code.
module ir_nec_frontend #(
  parameter int CLKS_PER_UNIT = 28125,
  parameter int TX_DIV        = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_in,
  output logic        serial,
  output logic        bit_tick,
  output logic        frame_valid,
  output logic [31:0] frame_data,
  output logic        overrun,
  output logic        err
);

  localparam int PW = $clog2(CLKS_PER_UNIT);
  localparam int DW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(CLKS_PER_UNIT - 1);
  localparam logic [DW-1:0] D_MAX = DW'(TX_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    BIT_LOW,
    BIT_HIGH,
    STOP_LOW
  } state_t;

  logic [1:0]    sync;
  logic [2:0]    hist;
  logic          lvl;
  logic          filt;
  logic          flip;
  logic          fall;
  logic [PW-1:0] presc;
  logic [4:0]    units;
  state_t        state;
  logic [4:0]    idx;
  logic [31:0]   shift_reg;
  logic          tx_start;
  logic          tx_active;
  logic [32:0]   tx_sh;
  logic [DW-1:0] div;
  logic [5:0]    left;
  logic [1:0]    gap;
  logic          busy;
`ifdef IR_REPEAT_EN
  logic          have_frame;
`endif

  // Everything after the header, in air order: 1, custom LSB-first,
  // key MSB-first, inverted key MSB-first.
  function automatic logic [32:0] tx_tail(input logic [31:0] d);
    logic [32:0] v;
    v[0] = 1'b1;
    for (int i = 0; i < 16; i++) v[1 + i] = d[i];
    for (int i = 0; i < 8; i++) begin
      v[17 + i] = d[23 - i];
      v[25 + i] = d[31 - i];
    end
    return v;
  endfunction

  assign filt = (hist[0] & hist[1]) | (hist[0] & hist[2]) |
                (hist[1] & hist[2]);
  assign flip = filt ^ lvl;
  assign fall = flip & ~filt;
  assign busy = tx_start | tx_active | (gap != 2'd0);

  // Synchronise the raw input and majority-filter three samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
      hist <= 3'b111;
      lvl  <= 1'b1;
    end else begin
      sync <= {sync[0], ir_in};
      hist <= {hist[1:0], sync[1]};
      lvl  <= filt;
    end
  end

  // Measure the current level width in NEC units; restart on each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      units <= '0;
    end else if (flip) begin
      presc <= '0;
      units <= '0;
    end else if (presc == P_MAX) begin
      presc <= '0;
      if (units != 5'd31) units <= units + 5'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Decode NEC edges into a frame and hand it to the replay unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      shift_reg   <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      err         <= 1'b0;
      tx_start    <= 1'b0;
`ifdef IR_REPEAT_EN
      have_frame  <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      err         <= 1'b0;
      tx_start    <= 1'b0;
      if (state != IDLE && !flip && units == 5'd31) begin
        err   <= 1'b1;
        state <= IDLE;
      end else if (flip) begin
        unique case (state)
          IDLE: begin
            if (fall) state <= LEAD_LOW;
          end
          LEAD_LOW: begin
            if (units >= 5'd13 && units <= 5'd19) begin
              state <= LEAD_HIGH;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
          LEAD_HIGH: begin
            if (units >= 5'd6 && units <= 5'd10) begin
              state <= BIT_LOW;
              idx   <= '0;
            end else if (units >= 5'd3 && units <= 5'd5) begin
`ifdef IR_REPEAT_EN
              if (have_frame) begin
                if (busy) begin
                  overrun <= 1'b1;
                end else begin
                  frame_valid <= 1'b1;
                  tx_start    <= 1'b1;
                end
              end
`endif
              state <= IDLE;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
          BIT_LOW: begin
            if (units <= 5'd2) begin
              state <= BIT_HIGH;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
          BIT_HIGH: begin
            if (units <= 5'd4) begin
              shift_reg[idx] <= (units >= 5'd2);
              if (idx == 5'd31) begin
                state <= STOP_LOW;
              end else begin
                idx   <= idx + 5'd1;
                state <= BIT_LOW;
              end
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
          STOP_LOW: begin
            state <= IDLE;
            if (units <= 5'd2) begin
              if (busy) begin
                overrun <= 1'b1;
              end else begin
                frame_data  <= shift_reg;
                frame_valid <= 1'b1;
                tx_start    <= 1'b1;
`ifdef IR_REPEAT_EN
                have_frame  <= 1'b1;
`endif
              end
            end else begin
              err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Replay header plus 32 data bits, TX_DIV clks each, then a re-arm gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      serial    <= 1'b1;
      bit_tick  <= 1'b0;
      tx_active <= 1'b0;
      tx_sh     <= '0;
      div       <= '0;
      left      <= '0;
      gap       <= '0;
    end else begin
      bit_tick <= 1'b0;
      if (tx_start) begin
        tx_sh     <= tx_tail(frame_data);
        serial    <= 1'b0;
        bit_tick  <= 1'b1;
        div       <= '0;
        left      <= 6'd33;
        tx_active <= 1'b1;
      end else if (tx_active) begin
        if (div == D_MAX) begin
          div <= '0;
          if (left == 6'd0) begin
            tx_active <= 1'b0;
            serial    <= 1'b1;
            gap       <= 2'd2;
          end else begin
            serial   <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            bit_tick <= 1'b1;
            left     <= left - 6'd1;
          end
        end else begin
          div <= div + 1'b1;
        end
      end else if (gap != 2'd0) begin
        gap <= gap - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_frontend.sv
// Directed bench for ir_nec_frontend.
// Two instances: fast unit/1-clk replay, and slow replay for overrun.
module tb_ir_nec_frontend;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ir1 = 1'b1;
  logic        ir2 = 1'b1;
  logic        s1, bt1, fv1, ov1, er1;
  logic        s2, bt2, fv2, ov2, er2;
  logic [31:0] fd1, fd2;

  int ncmp = 0;
  int nbad = 0;

  int cyc = 0;
  int nfv1 = 0, nov1 = 0, ner1 = 0, nz1 = 0;
  int nfv2 = 0, nov2 = 0, ner2 = 0;
  int fvc1 = 0, lat1 = -1, erc1 = 0;
  logic lat_pend = 1'b0;
  logic q1[$];
  logic q2[$];

  always #5 clk = ~clk;

  ir_nec_frontend #(.CLKS_PER_UNIT(4), .TX_DIV(1)) dut (
    .clk(clk), .reset(reset), .ir_in(ir1),
    .serial(s1), .bit_tick(bt1), .frame_valid(fv1),
    .frame_data(fd1), .overrun(ov1), .err(er1)
  );

  ir_nec_frontend #(.CLKS_PER_UNIT(2), .TX_DIV(8)) dut2 (
    .clk(clk), .reset(reset), .ir_in(ir2),
    .serial(s2), .bit_tick(bt2), .frame_valid(fv2),
    .frame_data(fd2), .overrun(ov2), .err(er2)
  );

  // Event monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bt1) q1.push_back(s1);
    if (bt2) q2.push_back(s2);
    if (!s1) nz1 <= nz1 + 1;
    if (ov1) nov1 <= nov1 + 1;
    if (er1) begin
      ner1 <= ner1 + 1;
      erc1 <= cyc;
    end
    if (fv2) nfv2 <= nfv2 + 1;
    if (ov2) nov2 <= nov2 + 1;
    if (er2) ner2 <= ner2 + 1;
    if (bt1 && lat_pend) begin
      lat1 <= cyc - fvc1;
      lat_pend <= 1'b0;
    end
    if (fv1) begin
      nfv1 <= nfv1 + 1;
      fvc1 <= cyc;
      lat_pend <= 1'b1;
    end
  end

  function automatic logic [33:0] exp_stream(input logic [31:0] d);
    logic [33:0] s;
    s = '0;
    s = {s[32:0], 1'b0};
    s = {s[32:0], 1'b1};
    for (int i = 0; i < 16; i++) s = {s[32:0], d[i]};
    for (int i = 23; i >= 16; i--) s = {s[32:0], d[i]};
    for (int i = 31; i >= 24; i--) s = {s[32:0], d[i]};
    return s;
  endfunction

  function automatic logic [33:0] got1();
    logic [33:0] g;
    g = '0;
    foreach (q1[k]) g = {g[32:0], q1[k]};
    return g;
  endfunction

  function automatic logic [33:0] got2();
    logic [33:0] g;
    g = '0;
    foreach (q2[k]) g = {g[32:0], q2[k]};
    return g;
  endfunction

  task automatic lvl1(input logic v, input int u);
    ir1 = v;
    repeat (u * 4) @(negedge clk);
  endtask

  task automatic lvl2(input logic v, input int u);
    ir2 = v;
    repeat (u * 2) @(negedge clk);
  endtask

  // Send a frame on dut; bad_bit >= 0 stretches that bit's space and aborts.
  task automatic send1(input logic [31:0] d, input int bad_bit,
                       input int bad_units);
    lvl1(1'b0, 16);
    lvl1(1'b1, 8);
    for (int i = 0; i < 32; i++) begin
      lvl1(1'b0, 1);
      if (i == bad_bit) begin
        lvl1(1'b1, bad_units);
        lvl1(1'b0, 1);
        ir1 = 1'b1;
        return;
      end
      lvl1(1'b1, d[i] ? 3 : 1);
    end
    lvl1(1'b0, 1);
    ir1 = 1'b1;
  endtask

  task automatic send2(input logic [31:0] d);
    lvl2(1'b0, 16);
    lvl2(1'b1, 8);
    for (int i = 0; i < 32; i++) begin
      lvl2(1'b0, 1);
      lvl2(1'b1, d[i] ? 3 : 1);
    end
    lvl2(1'b0, 1);
    ir2 = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    ncmp++;
    if (s1 !== 1'b1) begin
      nbad++; $display("FAIL rst_serial: got %b want 1", s1);
    end
    ncmp++;
    if (bt1 !== 1'b0) begin
      nbad++; $display("FAIL rst_tick: got %b want 0", bt1);
    end
    ncmp++;
    if (fv1 !== 1'b0 || ov1 !== 1'b0 || er1 !== 1'b0) begin
      nbad++;
      $display("FAIL rst_pulses: fv %b ov %b err %b want 0", fv1, ov1, er1);
    end
    ncmp++;
    if (fd1 !== 32'h0) begin
      nbad++; $display("FAIL rst_data: got %h want 0", fd1);
    end
    ncmp++;
    if (s2 !== 1'b1 || fd2 !== 32'h0) begin
      nbad++; $display("FAIL rst_dut2: serial %b data %h", s2, fd2);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_frame();
    int bfv, ber;
    bfv = nfv1; ber = ner1;
    q1.delete();
    send1(32'hE916_00FF, -1, 0);
    repeat (80) @(negedge clk);
    ncmp++;
    if (nfv1 - bfv !== 1) begin
      nbad++; $display("FAIL frame_valid: got %0d want 1", nfv1 - bfv);
    end
    ncmp++;
    if (fd1 !== 32'hE916_00FF) begin
      nbad++; $display("FAIL frame_data: got %h want e91600ff", fd1);
    end
    ncmp++;
    if (q1.size() !== 34) begin
      nbad++; $display("FAIL frame_ticks: got %0d want 34", q1.size());
    end
    ncmp++;
    if (got1() !== 34'b01_11111111_00000000_00010110_11101001) begin
      nbad++; $display("FAIL frame_serial: got %b", got1());
    end
    ncmp++;
    if (lat1 !== 1) begin
      nbad++; $display("FAIL replay_latency: got %0d want 1", lat1);
    end
    ncmp++;
    if (ner1 - ber !== 0) begin
      nbad++; $display("FAIL frame_err: got %0d want 0", ner1 - ber);
    end
  endtask

  task automatic test_bad_leader();
    int bfv, ber, bz;
    bfv = nfv1; ber = ner1; bz = nz1;
    q1.delete();
    lvl1(1'b0, 22);
    ir1 = 1'b1;
    repeat (40) @(negedge clk);
    ncmp++;
    if (ner1 - ber !== 1) begin
      nbad++; $display("FAIL lead_err: got %0d want 1", ner1 - ber);
    end
    ncmp++;
    if (nfv1 - bfv !== 0 || q1.size() !== 0) begin
      nbad++;
      $display("FAIL lead_noframe: fv %0d ticks %0d want 0", nfv1 - bfv,
               q1.size());
    end
    ncmp++;
    if (nz1 - bz !== 0) begin
      nbad++; $display("FAIL lead_serial: low clks %0d want 0", nz1 - bz);
    end
  endtask

  task automatic test_bad_space();
    int bfv, ber;
    bfv = nfv1; ber = ner1;
    send1(32'h1234_5678, 10, 6);
    repeat (60) @(negedge clk);
    ncmp++;
    if (ner1 - ber !== 1 || nfv1 - bfv !== 0) begin
      nbad++;
      $display("FAIL space_err: err %0d fv %0d want 1/0", ner1 - ber,
               nfv1 - bfv);
    end
    q1.delete();
    send1(32'h3CC3_A55A, -1, 0);
    repeat (80) @(negedge clk);
    ncmp++;
    if (nfv1 - bfv !== 1 || fd1 !== 32'h3CC3_A55A) begin
      nbad++;
      $display("FAIL space_recover: fv %0d data %h want 1/3cc3a55a",
               nfv1 - bfv, fd1);
    end
    ncmp++;
    if (q1.size() !== 34 || got1() !== exp_stream(32'h3CC3_A55A)) begin
      nbad++;
      $display("FAIL space_serial: got %b n %0d want %b", got1(), q1.size(),
               exp_stream(32'h3CC3_A55A));
    end
    ncmp++;
    if (ner1 - ber !== 1) begin
      nbad++; $display("FAIL space_err_total: got %0d want 1", ner1 - ber);
    end
  endtask

  task automatic test_timeout();
    int bfv, ber, t0;
    bfv = nfv1; ber = ner1;
    lvl1(1'b0, 16);
    lvl1(1'b1, 8);
    lvl1(1'b0, 1);
    lvl1(1'b1, 1);
    t0 = cyc;
    lvl1(1'b0, 40);
    ir1 = 1'b1;
    repeat (40) @(negedge clk);
    ncmp++;
    if (ner1 - ber !== 1 || nfv1 - bfv !== 0) begin
      nbad++;
      $display("FAIL timeout_err: err %0d fv %0d want 1/0", ner1 - ber,
               nfv1 - bfv);
    end
    ncmp++;
    if (erc1 - t0 < 126 || erc1 - t0 > 134) begin
      nbad++; $display("FAIL timeout_when: got %0d want 126..134", erc1 - t0);
    end
  endtask

  task automatic test_repeat();
    int bfv, ber;
    bfv = nfv1; ber = ner1;
    q1.delete();
    lvl1(1'b0, 16);
    lvl1(1'b1, 4);
    lvl1(1'b0, 1);
    ir1 = 1'b1;
    repeat (80) @(negedge clk);
    ncmp++;
    if (ner1 - ber !== 0) begin
      nbad++; $display("FAIL repeat_err: got %0d want 0", ner1 - ber);
    end
    ncmp++;
    if (fd1 !== 32'h3CC3_A55A) begin
      nbad++; $display("FAIL repeat_data: got %h want 3cc3a55a", fd1);
    end
`ifdef IR_REPEAT_EN
    ncmp++;
    if (nfv1 - bfv !== 1) begin
      nbad++; $display("FAIL repeat_fv: got %0d want 1", nfv1 - bfv);
    end
    ncmp++;
    if (q1.size() !== 34 || got1() !== exp_stream(32'h3CC3_A55A)) begin
      nbad++; $display("FAIL repeat_serial: got %b n %0d", got1(), q1.size());
    end
`else
    ncmp++;
    if (nfv1 - bfv !== 0 || q1.size() !== 0) begin
      nbad++;
      $display("FAIL repeat_ignored: fv %0d ticks %0d want 0", nfv1 - bfv,
               q1.size());
    end
`endif
  endtask

  task automatic test_overrun();
    int bfv, bov, ber;
    bfv = nfv2; bov = nov2; ber = ner2;
    q2.delete();
    send2(32'hE916_00FF);
    lvl2(1'b1, 2);
    send2(32'hE916_0000);
    repeat (400) @(negedge clk);
    ncmp++;
    if (nfv2 - bfv !== 1) begin
      nbad++; $display("FAIL ovr_fv: got %0d want 1", nfv2 - bfv);
    end
    ncmp++;
    if (nov2 - bov !== 1) begin
      nbad++; $display("FAIL ovr_pulse: got %0d want 1", nov2 - bov);
    end
    ncmp++;
    if (fd2 !== 32'hE916_00FF) begin
      nbad++; $display("FAIL ovr_data: got %h want e91600ff", fd2);
    end
    ncmp++;
    if (q2.size() !== 34 || got2() !== exp_stream(32'hE916_00FF)) begin
      nbad++; $display("FAIL ovr_serial: got %b n %0d", got2(), q2.size());
    end
    ncmp++;
    if (ner2 - ber !== 0) begin
      nbad++; $display("FAIL ovr_err: got %0d want 0", ner2 - ber);
    end
  endtask

  task automatic test_reset_mid();
    int bfv;
    bit seen;
    seen = 1'b0;
    send1(32'hE916_00FF, -1, 0);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (fv1) seen = 1'b1;
    end
    ncmp++;
    if (!seen) begin
      nbad++; $display("FAIL mid_fv: got none want pulse");
    end
    @(negedge clk);
    ncmp++;
    if (bt1 !== 1'b1 || s1 !== 1'b0) begin
      nbad++; $display("FAIL mid_header: tick %b serial %b want 1/0", bt1, s1);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    ncmp++;
    if (s1 !== 1'b1 || bt1 !== 1'b0) begin
      nbad++; $display("FAIL mid_abort: serial %b tick %b want 1/0", s1, bt1);
    end
    @(negedge clk);
    reset = 1'b0;
    bfv = nfv1;
    q1.delete();
    repeat (60) @(negedge clk);
    ncmp++;
    if (q1.size() !== 0 || nfv1 - bfv !== 0 || fd1 !== 32'h0) begin
      nbad++;
      $display("FAIL mid_quiet: ticks %0d fv %0d data %h want 0", q1.size(),
               nfv1 - bfv, fd1);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bad_leader();
    test_bad_space();
    test_timeout();
    test_repeat();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
